booth_mul_seq_r4: RTL
=====================

# booth_mul_seq_r4

Iterative, parametrised radix-4 Booth multiplier with a valid/ready handshake on both sides and a runtime signed/unsigned mode select. It is the area-reduced successor to the single-cycle 64-bit signed Booth multiplier. It retires one Booth digit per clock, so a WIDTH-bit multiply costs one shared adder instead of a full partial-product tree. It sits behind the same operand/result naming as the combinational unit and is intended for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 64, operand width in bits; must be even and >= 4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operands and mode are valid this cycle.
- in_ready_o  output  1  block can accept operands; high only in IDLE.
- a_i  input  WIDTH  multiplicand.
- b_i  input  WIDTH  multiplier.
- signed_i  input  1  1 = both operands two's complement; 0 = both unsigned. Sampled with the operands.
- out_valid_o  output  1  result_o holds a completed product.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  2*WIDTH  exact product.

## Operation
- Decided: one clock (clk); reset is synchronous and active-high (rst).
- Operand extension: on acceptance, extend a_i and b_i to WIDTH+2 bits, filling with (signed_i & msb). This makes both modes a signed multiply.
- Digit count: N = WIDTH/2 + 1 (33 for WIDTH=64). Digits come from overlapping 3-bit groups of the extended b, with an implicit 0 below the LSB.
- Digit values are in {-2,-1,0,+1,+2}. Partial product = digit × extended a, formed by shift and/or two's-complement negate.
- Accumulate in a register of at least 2*WIDTH+4 bits. Apply the arithmetic shift-by-2 or weight-by-4^k so the final value is exact. result_o is the low 2*WIDTH bits, which always represent the true product exactly in both modes.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready_o=1. If in_valid_i is high at an edge, latch a, b and signed_i, clear the accumulator, set the digit counter to 0, and go to CALC.
  - CALC: in_ready_o=0, out_valid_o=0. Each edge processes one digit and increments the counter. On the edge that processes digit N-1, load result_o and go to DONE.
  - DONE: out_valid_o=1 and result_o is held stable. On an edge with out_ready_i=1, go to IDLE with out_valid_o=0.
- Operand inputs are ignored outside an IDLE acceptance edge. Changing a_i, b_i or signed_i after acceptance has no effect.
- in_valid_i asserted in CALC or DONE is not accepted. The producer must hold it until it sees in_ready_o=1.
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, result_o=0, counter=0, accumulator=0.
- rst has priority at any edge, including mid-CALC and in DONE with out_valid_o high. The in-flight operation is discarded, no result is produced, and the outputs return to their reset values at that edge.

## Timing
- Edge k means the k-th rising edge after the accepting edge (edge 0); cycle k is the interval that follows edge k.
- All outputs are registered. There are no combinational input-to-output paths, and in_ready_o is decoded from the state register.
- Latency: out_valid_o is first high in cycle N (cycle 33 for WIDTH=64), independent of operand values.
- If out_ready_i is already high in cycle N, the result transfers at edge N+1, and in_ready_o is high in cycle N+1.
- The earliest next acceptance is edge N+2, giving a back-to-back period of N+2 cycles.
- With out_ready_i low, DONE persists indefinitely. result_o, out_valid_o=1 and in_ready_o=0 stay unchanged.

## Test plan
- Reset: assert rst for 2 cycles, then release. Required: in_ready_o=1, out_valid_o=0, result_o=0. Then accept 5×7 signed, assert rst at cycle 10 of CALC, and release it. Required: no out_valid_o pulse ever; in_ready_o=1 in the cycle after the reset edge.
- Signed corners at WIDTH=64, each delivering out_valid_o in cycle 33:
  - 0×0 -> 0.
  - -1×-1 -> 1.
  - -2^63×1 -> 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000.
  - -2^63×-1 -> 2^63.
  - 2^62×2^62 -> 2^124.
  - -36×42 -> -1512.
- Unsigned mode (signed_i=0): 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. 2^63×2 -> 2^64.
- Backpressure: hold out_ready_i low for 10 cycles after out_valid_o rises, and pulse in_valid_i with new operands during that time. Required: result_o stable, in_ready_o=0, new operands not accepted. Raise out_ready_i: the result transfers on the next edge, and the new operands are accepted no earlier than the following edge.
- Throughput: in_valid_i and out_ready_i held high continuously, 20 random signed pairs at WIDTH=64. Required: accepting edges spaced exactly 35 cycles apart, every result equal to the reference model's exact product.
- Parametrisation: WIDTH=8, exhaustive 256×256 operand sweep in both modes. Required: every result matches the exact 16-bit product. Results delivered in cycle 5 after acceptance (N=5).

Source files
------------

// File: rtl/booth_mul_seq_r4.sv
// booth_mul_seq_r4: iterative radix-4 Booth multiplier with valid/ready handshakes.
// One Booth digit is retired per clock through a single shared adder. Both operands
// are extended by two bits (sign or zero, per signed_i) so every multiply is signed.
module booth_mul_seq_r4 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] result_o
);

    // Extended operand width, running high-part width, digit count and counter width.
    localparam int unsigned ExtW      = WIDTH + 2;
    localparam int unsigned AccW      = WIDTH + 4;
    localparam int unsigned NumDigits = WIDTH / 2 + 1;
    localparam int unsigned CntW      = $clog2(NumDigits);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e              r_state;
    logic [ExtW-1:0]     r_a;       // extended multiplicand
    logic [ExtW:0]       r_b;       // extended multiplier with implicit 0 below the LSB
    logic [AccW-1:0]     r_h;       // running high part, in units of 4^k
    logic [WIDTH-1:0]    r_l;       // retired low product bits, two per digit
    logic [CntW-1:0]     r_cnt;
    logic [2*WIDTH-1:0]  r_result;

    logic [ExtW-1:0]     w_a_ext;
    logic [ExtW-1:0]     w_b_ext;
    logic [2:0]          w_digit;
    logic                w_neg;
    logic                w_two;
    logic                w_zero;
    logic [AccW-1:0]     w_a1;
    logic [AccW-1:0]     w_a2;
    logic [AccW-1:0]     w_pp;
    logic [AccW-1:0]     w_addend;
    logic [AccW-1:0]     w_sum;
    logic [AccW-1:0]     w_h_next;
    logic [WIDTH-1:0]    w_l_next;

    // Unsigned mode zero-fills, signed mode sign-fills; both then multiply as signed.
    assign w_a_ext = {{2{signed_i & a_i[WIDTH-1]}}, a_i};
    assign w_b_ext = {{2{signed_i & b_i[WIDTH-1]}}, b_i};

    assign in_ready_o  = (r_state == StIdle);
    assign out_valid_o = (r_state == StDone);
    assign result_o    = r_result;

    // Booth digit decode, partial product selection and the shared add/shift step.
    always_comb begin
        w_digit  = r_b[2:0];
        w_zero   = (w_digit == 3'b000) || (w_digit == 3'b111);
        w_two    = (w_digit == 3'b011) || (w_digit == 3'b100);
        w_neg    = w_digit[2] && !(w_digit[1] && w_digit[0]);
        w_a1     = {{2{r_a[ExtW-1]}}, r_a};
        w_a2     = {r_a[ExtW-1], r_a, 1'b0};
        w_pp     = '0;
        if (!w_zero) begin
            w_pp = w_two ? w_a2 : w_a1;
        end
        // Negation as invert plus carry-in folded into the same adder.
        w_addend = w_neg ? ~w_pp : w_pp;
        w_sum    = r_h + w_addend + AccW'(w_neg);
        w_h_next = {{2{w_sum[AccW-1]}}, w_sum[AccW-1:2]};
        w_l_next = {w_sum[1:0], r_l[WIDTH-1:2]};
    end

    // Control FSM and datapath registers; rst discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_h      <= '0;
            r_l      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid_i) begin
                        r_a     <= w_a_ext;
                        r_b     <= {w_b_ext, 1'b0};
                        r_h     <= '0;
                        r_l     <= '0;
                        r_cnt   <= '0;
                        r_state <= StCalc;
                    end
                end
                StCalc: begin
                    r_h   <= w_h_next;
                    r_l   <= w_l_next;
                    r_b   <= {2'b00, r_b[ExtW:2]};
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == LastCnt) begin
                        // r_l holds exactly the first N-1 digit pairs at this point.
                        r_result <= {w_h_next[WIDTH-3:0], w_sum[1:0], r_l};
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
